// File: rtl/rr_stream_mux_pkg.sv
// Shared types and the round-robin search used by the stream mux and its arbiter.
package rr_stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // The search is written for up to RR_MAX_CH channels; wider muxes need a wider index.
    localparam int RR_MAX_CH = 64;
    localparam int RR_IDXW   = 6;

    typedef struct packed {
        logic               found;
        logic [RR_IDXW-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0], starting just after last and wrapping.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] valid,
                                         input int last,
                                         input int n);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = 1; k <= RR_MAX_CH; k++) begin
            if (k <= n) begin
                c = last + k;
                if (c >= n)
                    c = c - n;
                if (!r.found && valid[c[RR_IDXW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = c[RR_IDXW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: request vector and previous winner in,
// one-hot grant and winner index out.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int SELW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] last,
    output logic            found,
    output logic [N_CH-1:0] grant,
    output logic [SELW-1:0] idx
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(RR_MAX_CH'(req), int'(last), N_CH);
        found = pick.found;
        idx   = SELW'(pick.idx);
        grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (pick.found && pick.idx == RR_IDXW'(i))
                grant[i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with fixed-select or round-robin selection
// feeding a single registered output stage.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    input  logic                  out_ready
);

    logic             load;
    logic             fix_found;
    logic [N_CH-1:0]  fix_grant;
    logic             rr_found;
    logic [N_CH-1:0]  rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic             win_found;
    logic [N_CH-1:0]  win_grant;
    logic [SELW-1:0]  win_idx;
    logic             take;
    logic [SELW-1:0]  last_grant;
    logic [WIDTH-1:0] mux_data;

    rr_arbiter #(
        .N_CH (N_CH),
        .SELW (SELW)
    ) u_arb (
        .req   (in_valid),
        .last  (last_grant),
        .found (rr_found),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    assign load = !out_valid || out_ready;

    // An out-of-range sel matches no channel, so it simply grants nothing.
    always_comb begin
        fix_found = 1'b0;
        fix_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                fix_found    = 1'b1;
                fix_grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode_e'(mode) == MODE_RR) begin
            win_found = rr_found;
            win_grant = rr_grant;
            win_idx   = rr_idx;
        end else begin
            win_found = fix_found;
            win_grant = fix_grant;
            win_idx   = sel;
        end
    end

    assign take     = rst_n && load && win_found;
    assign in_ready = take ? win_grant : '0;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_idx == SELW'(i))
                mux_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Pointer starts at the top channel so channel 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SELW'(N_CH - 1);
        end else if (take) begin
            out_valid  <= 1'b1;
            out_data   <= mux_data;
            out_ch     <= win_idx;
            last_grant <= win_idx;
        end else if (load) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Randomized and directed bench for rr_stream_mux against a cycle-level reference model.
module tb_rr_stream_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n, mode, out_ready, out_valid;
    logic [1:0]     sel, out_ch;
    logic [N-1:0]   in_valid, in_ready;
    logic [N*W-1:0] in_data;
    logic [W-1:0]   out_data;

    logic           rst3_n, mode3, out_ready3, out_valid3;
    logic [1:0]     sel3, out_ch3;
    logic [2:0]     in_valid3, in_ready3;
    logic [23:0]    in_data3;
    logic [7:0]     out_data3;

    int n_chk  = 0;
    int n_fail = 0;

    bit m_ov;
    int m_data, m_ch, m_last;

    always #5 clk = ~clk;

    rr_stream_mux #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    rr_stream_mux #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel that should be granted this cycle, or -1.
    function automatic int predict();
        if (!rst_n) return -1;
        if (m_ov && !out_ready) return -1;
        if (mode == 1'b0)
            return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        int           g;
        logic [N-1:0] exp_rdy;
        bit           ld;
        #2;
        g       = predict();
        ld      = !m_ov || out_ready;
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_ov = 0; m_data = 0; m_ch = 0; m_last = N - 1;
        end else if (g >= 0) begin
            m_ov = 1; m_data = int'(in_data[g*W +: W]); m_ch = g; m_last = g;
        end else if (ld) begin
            m_ov = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    task automatic step3(input string tag, input logic [2:0] erdy, input logic eov,
                         input logic [1:0] ech, input logic [7:0] edat);
        #2;
        chk({tag, "_rdy"}, 32'(in_ready3), 32'(erdy));
        @(posedge clk);
        #1;
        chk({tag, "_ov"}, 32'(out_valid3), 32'(eov));
        if (eov) begin
            chk({tag, "_ch"}, 32'(out_ch3), 32'(ech));
            chk({tag, "_data"}, 32'(out_data3), 32'(edat));
        end
    endtask

    initial begin
        m_ov = 0; m_data = 0; m_ch = 0; m_last = N - 1;
        rst_n = 0; mode = 0; sel = 0; out_ready = 1;
        in_valid = 4'b1111;
        in_data  = 32'h13121110;
        rst3_n = 0; mode3 = 0; sel3 = 0; out_ready3 = 1;
        in_valid3 = 3'b111; in_data3 = 24'h222120;

        // Reset with all inputs valid
        step(); step();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst_n = 1; mode = 1;
        step();
        chk("first_grant", 32'(out_ch), 32'd0);

        // Fixed select of channel 2
        mode = 0; sel = 2;
        for (int i = 0; i < 3; i++) begin
            #2 chk("fix_rdy", 32'(in_ready), 32'h4);
            step();
            chk("fix_data", 32'(out_data), 32'h12);
        end

        // Round-robin fairness from reset
        rst_n = 0; step(); rst_n = 1; mode = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_ch", 32'(out_ch), 32'(i % N));
            chk("rr_data", 32'(out_data), 32'(8'h10 + i % N));
        end

        // Backpressure holding the ch1 beat, then no-bubble reload
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_data", 32'(out_data), 32'h11);
        end
        out_ready = 1;
        step();
        chk("bp_next", 32'(out_ch), 32'd2);

        // Sparse round-robin with wrap, then drain
        rst_n = 0; step(); rst_n = 1;
        in_valid = 4'b1010;
        step(); chk("sparse0", 32'(out_ch), 32'd1);
        step(); chk("sparse1", 32'(out_ch), 32'd3);
        step(); chk("sparse2", 32'(out_ch), 32'd1);
        in_valid = 4'b0000;
        step(); chk("drain", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 80) != 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Three-channel instance: out-of-range select and mid-transfer reset
        step3("r3", 3'b000, 1'b0, 2'd0, 8'h00);
        rst3_n = 1; sel3 = 3;
        step3("oor", 3'b000, 1'b0, 2'd0, 8'h00);
        step3("oor2", 3'b000, 1'b0, 2'd0, 8'h00);
        sel3 = 1;
        step3("fix3", 3'b010, 1'b1, 2'd1, 8'h21);
        sel3 = 0; out_ready3 = 0;
        step3("hold3", 3'b000, 1'b1, 2'd1, 8'h21);
        rst3_n = 0;
        step3("mrst", 3'b000, 1'b0, 2'd0, 8'h00);
        rst3_n = 1; out_ready3 = 1; mode3 = 1;
        step3("rr3", 3'b001, 1'b1, 2'd0, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
